// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - size codes, access bit positions, FSM states and store lane helpers
package lsu_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int ACC_ST = 2;
  localparam int ACC_U  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    store_strb = 4'b0001 << lane;
      SZ_H:    store_strb = 4'b0011 << {lane[1], 1'b0};
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across every lane so the strobes alone pick the bytes.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_B:    store_data = {4{d[7:0]}};
      SZ_H:    store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - data memory req/gnt/rvalid port shared by the LSU and the memory
interface lsu_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl_load_ext.sv
// rtl/lsu_ctrl_load_ext.sv - lsu_load_ext: selects the load lane and sign/zero-extends it
module lsu_load_ext
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sgn;

  always_comb begin
    byte_v = mem_rdata[7:0];
    case (lane)
      2'd1:    byte_v = mem_rdata[15:8];
      2'd2:    byte_v = mem_rdata[23:16];
      2'd3:    byte_v = mem_rdata[31:24];
      default: byte_v = mem_rdata[7:0];
    endcase
    half_v = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    sgn    = ~unsigned_ld;
    case (size)
      SZ_B:    rdata = {{24{sgn & byte_v[7]}}, byte_v};
      SZ_H:    rdata = {{16{sgn & half_v[15]}}, half_v};
      default: rdata = mem_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - LA32R load/store sequencer; define LSU_MISALIGN_CHECK_EN to fault unaligned H/W accesses
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic [3:0]  dmem_access,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        lsu_stall,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] rdata,
  lsu_ctrl_if.master  mem
);

  lsu_state_e       state, state_nxt;
  logic [3:0]       acc_q;
  logic [1:0]       lane_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      ext_data;
  logic             bad_req;
  logic             timeout;
  logic             load_done;
  logic             st_done;

  lsu_load_ext u_load_ext (
    .size        (acc_q[1:0]),
    .unsigned_ld (acc_q[ACC_U]),
    .lane        (lane_q),
    .mem_rdata   (mem.mem_rdata),
    .rdata       (ext_data)
  );

  always_comb begin
    bad_req = (dmem_access[1:0] == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
    if (dmem_access[1:0] == SZ_H && addr[0])
      bad_req = 1'b1;
    if (dmem_access[1:0] == SZ_W && addr[1:0] != 2'b00)
      bad_req = 1'b1;
`endif
  end

  assign lsu_stall = (state == S_IDLE && req_valid) || state == S_REQ || state == S_WAIT;
  // Fires on the last allowed REQ/WAIT cycle so exactly TIMEOUT_CYCLES are spent there.
  assign timeout   = (state == S_REQ || state == S_WAIT) && cnt == CNT_W'(TIMEOUT_CYCLES - 1);

  always_comb begin
    state_nxt = state;
    load_done = 1'b0;
    st_done   = 1'b0;
    case (state)
      S_IDLE: if (req_valid) state_nxt = bad_req ? S_RESP : S_REQ;
      S_REQ: begin
        if (mem.mem_gnt) begin
          if (acc_q[ACC_ST]) begin
            st_done   = 1'b1;
            state_nxt = S_RESP;
          end else if (mem.mem_rvalid) begin
            load_done = 1'b1;
            state_nxt = S_RESP;
          end else begin
            state_nxt = timeout ? S_RESP : S_WAIT;
          end
        end else if (timeout) begin
          state_nxt = S_RESP;
        end
      end
      S_WAIT: begin
        if (mem.mem_rvalid) begin
          load_done = 1'b1;
          state_nxt = S_RESP;
        end else if (timeout) begin
          state_nxt = S_RESP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      acc_q         <= 4'b0;
      lane_q        <= 2'b0;
      cnt           <= '0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      rdata         <= 32'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'b0;
      mem.mem_wstrb <= 4'b0;
      mem.mem_wdata <= 32'b0;
    end else begin
      state      <= state_nxt;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      if (state == S_REQ || state == S_WAIT)
        cnt <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            acc_q  <= dmem_access;
            lane_q <= addr[1:0];
            cnt    <= '0;
            if (bad_req) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              rdata      <= 32'b0;
            end else begin
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= dmem_access[ACC_ST];
              mem.mem_addr  <= {addr[31:2], 2'b00};
              mem.mem_wstrb <= dmem_access[ACC_ST] ? store_strb(dmem_access[1:0], addr[1:0]) : 4'b0000;
              mem.mem_wdata <= store_data(dmem_access[1:0], wdata);
            end
          end
        end
        S_REQ, S_WAIT: begin
          if (state_nxt == S_RESP) begin
            mem.mem_req <= 1'b0;
            resp_valid  <= 1'b1;
            if (load_done) begin
              rdata <= ext_data;
            end else if (!st_done) begin
              resp_err <= 1'b1;
              rdata    <= 32'b0;
            end
          end else if (state_nxt == S_WAIT) begin
            mem.mem_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  dmem_access = 4'b0;
  logic [31:0] addr = 32'b0;
  logic [31:0] wdata = 32'b0;
  logic        lsu_stall;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;

  lsu_ctrl_if mem_bus();

  int n_tests = 0;
  int n_fail  = 0;

  int          lat, req_cyc, stall_bad, unstable;
  logic        stall_acc, cap_we, r_err, r_req, after_valid, after_req;
  logic [3:0]  cap_wstrb;
  logic [31:0] cap_addr, cap_wdata, r_data;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .dmem_access (dmem_access),
    .addr        (addr),
    .wdata       (wdata),
    .lsu_stall   (lsu_stall),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .rdata       (rdata),
    .mem         (mem_bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one access at a negedge. gnt_dly: REQ cycle index (0-based) of gnt, -1 = never.
  // rv_dly: cycles after gnt for rvalid (0 = same cycle), -1 = never. lat counts negedges after accept.
  task automatic run_access(input logic [3:0] acc, input logic [31:0] a, input logic [31:0] wd,
                            input int gnt_dly, input int rv_dly, input logic [31:0] rd);
    lat = -1; req_cyc = 0; stall_bad = 0; unstable = 0;
    cap_we = 1'b0; cap_wstrb = 4'b0; cap_addr = 32'b0; cap_wdata = 32'b0;
    r_err = 1'b0; r_data = 32'b0; r_req = 1'b0;
    dmem_access = acc; addr = a; wdata = wd; req_valid = 1'b1;
    #1 stall_acc = lsu_stall;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (resp_valid) begin
        lat = k; r_err = resp_err; r_data = rdata; r_req = mem_bus.mem_req;
        break;
      end
      if (!lsu_stall) stall_bad++;
      if (mem_bus.mem_req) begin
        if (req_cyc == 0) begin
          cap_we = mem_bus.mem_we; cap_wstrb = mem_bus.mem_wstrb;
          cap_addr = mem_bus.mem_addr; cap_wdata = mem_bus.mem_wdata;
        end else if (mem_bus.mem_addr !== cap_addr || mem_bus.mem_wstrb !== cap_wstrb ||
                     mem_bus.mem_wdata !== cap_wdata || mem_bus.mem_we !== cap_we) begin
          unstable++;
        end
        req_cyc++;
      end
      mem_bus.mem_gnt    = (gnt_dly >= 0) && (k - 1 == gnt_dly);
      mem_bus.mem_rvalid = (gnt_dly >= 0) && (rv_dly >= 0) && (k - 1 == gnt_dly + rv_dly);
      mem_bus.mem_rdata  = mem_bus.mem_rvalid ? rd : 32'hDEAD_BEEF;
      @(negedge clk);
    end
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0;
    @(negedge clk);
    after_valid = resp_valid; after_req = mem_bus.mem_req;
  endtask

  initial begin
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'b0;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_mem_req", mem_bus.mem_req, 0);
    check("rst_mem_we", mem_bus.mem_we, 0);
    check("rst_wstrb", mem_bus.mem_wstrb, 0);
    check("rst_mem_addr", mem_bus.mem_addr, 0);
    check("rst_mem_wdata", mem_bus.mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_stall", lsu_stall, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_access(4'b0000, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234);
    check("ldb_stall_accept", stall_acc, 1);
    check("ldb_latency", lat, 2);
    check("ldb_rdata", r_data, 32'hFFFF_FF80);
    check("ldb_err", r_err, 0);
    check("ldb_wstrb", cap_wstrb, 4'b0000);
    check("ldb_addr", cap_addr, 32'h0000_1000);
    check("ldb_pulse", after_valid, 0);

    run_access(4'b0101, 32'h0000_2002, 32'h0000_BEEF, 2, -1, 32'h0);
    check("sth_req_cycles", req_cyc, 3);
    check("sth_stable", unstable, 0);
    check("sth_we", cap_we, 1);
    check("sth_wstrb", cap_wstrb, 4'b1100);
    check("sth_wdata", cap_wdata, 32'hBEEF_BEEF);
    check("sth_addr", cap_addr, 32'h0000_2000);
    check("sth_latency", lat, 4);
    check("sth_err", r_err, 0);

    run_access(4'b1001, 32'h0000_3002, 32'h0, 0, 5, 32'hA5A5_0000);
    check("ldhu_rdata", r_data, 32'h0000_A5A5);
    check("ldhu_stall", stall_bad, 0);
    check("ldhu_latency", lat, 7);
    check("ldhu_req_cycles", req_cyc, 1);

    dmem_access = 4'b0010; addr = 32'h0000_9000; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; mem_bus.mem_gnt = 1'b1;
    @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    check("rstw_req_dropped", mem_bus.mem_req, 0);
    check("rstw_stall_wait", lsu_stall, 1);
    rstn = 1'b0;
    #1;
    check("rstw_async_rdata", rdata, 0);
    check("rstw_async_addr", mem_bus.mem_addr, 0);
    check("rstw_async_stall", lsu_stall, 0);
    @(negedge clk);
    rstn = 1'b1; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("rstw_stale_valid0", resp_valid, 0);
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    check("rstw_stale_valid1", resp_valid, 0);
    check("rstw_stale_rdata", rdata, 0);
    check("rstw_idle", lsu_stall, 0);

    run_access(4'b0010, 32'h0000_6000, 32'h0, -1, -1, 32'h0);
    check("tmo_latency", lat, 65);
    check("tmo_req_cycles", req_cyc, 64);
    check("tmo_err", r_err, 1);
    check("tmo_rdata", r_data, 0);
    check("tmo_req_at_resp", r_req, 0);
    check("tmo_req_after", after_req, 0);

    run_access(4'b0010, 32'h0000_4001, 32'h0, 0, 0, 32'h1234_5678);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_latency", lat, 1);
    check("mis_req_cycles", req_cyc, 0);
    check("mis_err", r_err, 1);
    check("mis_rdata", r_data, 0);
`else
    check("mis_latency", lat, 2);
    check("mis_addr", cap_addr, 32'h0000_4000);
    check("mis_err", r_err, 0);
    check("mis_rdata", r_data, 32'h1234_5678);
`endif

    run_access(4'b0011, 32'h0000_7000, 32'h0, 0, 0, 32'h0);
    check("ill_latency", lat, 1);
    check("ill_req_cycles", req_cyc, 0);
    check("ill_err", r_err, 1);

    run_access(4'b0100, 32'h0000_8001, 32'h1234_56A7, 0, -1, 32'h0);
    check("stb_wstrb", cap_wstrb, 4'b0010);
    check("stb_wdata", cap_wdata, 32'hA7A7_A7A7);
    check("stb_latency", lat, 2);

    run_access(4'b0001, 32'h0000_5000, 32'h0, 1, 0, 32'h0000_8001);
    check("ldh_rdata", r_data, 32'hFFFF_8001);
    check("ldh_latency", lat, 3);

    run_access(4'b1000, 32'h0000_5002, 32'h0, 0, 2, 32'h00C3_0000);
    check("ldbu_rdata", r_data, 32'h0000_00C3);
    check("ldbu_latency", lat, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
